nt_node_lane_array: RTL and testbench
=====================================

Name: nt_node_lane_array

Overview:
- Parametrised, multi-lane successor of the single-bit Nt-node subcircuit used in the trojan-detection benchmark netlists.
- Each lane computes y = NOT reg( NOR(b, reg(a)) OR reg(c) ), with all three operands latency-aligned.
- Adds a valid/stall pipeline and a sticky rare-event trigger monitor on the outputs.
- Sits between benchmark stimulus logic and the detection scoreboard.

Parameters:
- WIDTH, 8: number of independent lanes.
- CNT_W, 8: width of the saturating event counter.
- THRESH, 16: event count at which trig asserts; legal range 1..2^CNT_W-1.
- EVT_MASK, all ones (WIDTH bits): lanes that participate in event detection.

Ports:
- I1470_clk  in  1  sole clock, rising edge.
- I1477_rst  in  1  reset, asynchronous, active-low.
- en  in  1  pipeline advance; 0 stalls every register except clr handling.
- in_valid  in  1  the a/b/c inputs are valid this cycle.
- a  in  WIDTH  operand registered before the NOR.
- b  in  WIDTH  operand fed straight into the NOR; registered once for alignment.
- c  in  WIDTH  operand ORed with the NOR result.
- clr  in  1  synchronous clear of the counter and trig.
- out_valid  out  1  y is valid.
- y  out  WIDTH  lane results.
- evt_cnt  out  CNT_W  saturating count of events.
- trig  out  1  sticky threshold flag.

Behaviour:
- Stage 1, when en=1: a_q<=a, b_q<=b, c_q<=c, v1<=in_valid.
- Stage 2, when en=1: o_q <= ~(b_q|a_q) | c_q, bitwise; v2<=v1.
- y = ~o_q (combinational from o_q). out_valid = v2.
- Latency is exactly 2 enabled cycles from inputs to y for every operand.
- en=0: all pipeline registers hold; y and out_valid are held constant.
- Invalid data still flows through the pipeline. y is meaningful only when out_valid=1.
- Event definition: out_valid && en && |(y & EVT_MASK).
- Counter, on each event: evt_cnt <= evt_cnt+1. It saturates at 2^CNT_W-1 and never wraps.
- trig is set in the cycle after evt_cnt first reaches a value >= THRESH. It then stays set until clr or reset.
- clr=1 has priority over a same-cycle event: evt_cnt<=0 and trig<=0; that event is not counted.
- clr acts regardless of en.
- Reset (I1477_rst=0), asynchronous:
  - All registers go to 0.
  - Therefore y = all ones (inverted output stage), out_valid=0, evt_cnt=0, trig=0.
  - No event is counted while out_valid=0.
- Reset asserted mid-stream discards all in-flight data. On release, the first out_valid appears 2 enabled cycles after the first in_valid.

Optional Feature:
- NT_NODE_PARITY_EN defined:
  - Adds output y_par (1 bit) = ^y, registered alongside o_q. y_par is the parity of the ones-complement, and its reset value equals WIDTH mod 2.
  - Adds a parity-error sticky bit perr, set when out_valid and a recomputed ^y differs from y_par. perr is cleared by clr or reset.
- Not defined: y_par and perr ports do not exist; no extra registers.

Decomposition:
- Package nt_node_pkg:
  - localparam defaults for WIDTH, CNT_W and THRESH.
  - typedef lane_t = logic [WIDTH-1:0].
  - function sat_inc(cnt) for the saturating increment.
- Sub-module nt_node_lane: the single-lane datapath (a_q, b_q, c_q, o_q), instantiated WIDTH times via generate.
- The valid pipeline, counter and trig stay in the top module.

Test Plan:
- Reset check: hold I1477_rst=0 with random inputs -> y=0xFF, out_valid=0, evt_cnt=0, trig=0.
- Release reset, then a=0x00, b=0x00, c=0x00, in_valid=1, en=1 for 1 cycle -> 2 cycles later y=0x00, out_valid=1.
- Truth table on lane k over all 8 combinations of a, b, c -> y[k]=1 only when c=0 and (a|b)=1.
- Stall: toggle en=0 for 3 cycles mid-stream -> y and out_valid frozen; no events counted.
- Threshold: THRESH=16, drive a=0x01, b=0, c=0 continuously -> trig rises the cycle after evt_cnt=16.
- Saturation and clear: drive 300 events -> evt_cnt=255 and holds. Then clr=1 coincident with an event -> evt_cnt=0, trig=0.

Source files
------------

// File: rtl/nt_node_pkg.sv
// Shared defaults, lane type and saturating-increment helper for the Nt-node lane array.
package nt_node_pkg;

   localparam int unsigned WIDTH_DEF  = 8;
   localparam int unsigned CNT_W_DEF  = 8;
   localparam int unsigned THRESH_DEF = 16;

   typedef logic [WIDTH_DEF-1:0] lane_t;

   // Increments cnt but never past max.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
      return (cnt >= max) ? max : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/nt_node_lane_array_if.sv
// Stimulus/result bundle of the Nt-node lane array; NT_NODE_PARITY_EN adds y_par and perr.
interface nt_node_lane_array_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             clr;
   logic             out_valid;
   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] evt_cnt;
   logic             trig;
`ifdef NT_NODE_PARITY_EN
   logic             y_par;
   logic             perr;
`endif

   modport master (
      output en, in_valid, a, b, c, clr,
      input  out_valid, y, evt_cnt, trig
`ifdef NT_NODE_PARITY_EN
      , input y_par, perr
`endif
   );

   modport slave (
      input  en, in_valid, a, b, c, clr,
      output out_valid, y, evt_cnt, trig
`ifdef NT_NODE_PARITY_EN
      , output y_par, perr
`endif
   );
endinterface

// File: rtl/nt_node_lane.sv
// Single-lane Nt-node datapath: o = NOR(b, a) OR c, all operands aligned to two stages.
module nt_node_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic o_d,
   output logic o_q
);
   logic a_q, b_q, c_q;

   assign o_d = ~(b_q | a_q) | c_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= 1'b0;
         b_q <= 1'b0;
         c_q <= 1'b0;
         o_q <= 1'b0;
      end else if (en) begin
         a_q <= a;
         b_q <= b;
         c_q <= c;
         o_q <= o_d;
      end
   end
endmodule

// File: rtl/nt_node_lane_array.sv
// WIDTH-lane Nt-node array with valid pipeline and sticky rare-event trigger monitor.
// Optional macro NT_NODE_PARITY_EN adds registered output parity y_par and sticky perr.
module nt_node_lane_array
   import nt_node_pkg::*;
#(
   parameter int unsigned      WIDTH    = WIDTH_DEF,
   parameter int unsigned      CNT_W    = CNT_W_DEF,
   parameter int unsigned      THRESH   = THRESH_DEF,
   parameter logic [WIDTH-1:0] EVT_MASK = '1
) (
   input logic                 I1470_clk,
   input logic                 I1477_rst,
   nt_node_lane_array_if.slave bus
);
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic             v1, v2;
   logic [WIDTH-1:0] o_d, o_q, y;
   logic [CNT_W-1:0] evt_cnt_q;
   logic             trig_q;
   logic             evt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nt_node_lane u_lane (
         .clk   (I1470_clk),
         .rst_n (I1477_rst),
         .en    (bus.en),
         .a     (bus.a[i]),
         .b     (bus.b[i]),
         .c     (bus.c[i]),
         .o_d   (o_d[i]),
         .o_q   (o_q[i])
      );
   end

   // Inverted output stage: a cleared pipeline reads as all ones.
   assign y   = ~o_q;
   assign evt = v2 && bus.en && |(y & EVT_MASK);

   always_ff @(posedge I1470_clk or negedge I1477_rst) begin
      if (!I1477_rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else if (bus.en) begin
         v1 <= bus.in_valid;
         v2 <= v1;
      end
   end

   // clr outranks a same-cycle event and works even while stalled.
   always_ff @(posedge I1470_clk or negedge I1477_rst) begin
      if (!I1477_rst) begin
         evt_cnt_q <= '0;
         trig_q    <= 1'b0;
      end else if (bus.clr) begin
         evt_cnt_q <= '0;
         trig_q    <= 1'b0;
      end else begin
         if (evt) evt_cnt_q <= CNT_W'(sat_inc(32'(evt_cnt_q), CNT_MAX));
         if (evt_cnt_q >= CNT_W'(THRESH)) trig_q <= 1'b1;
      end
   end

   assign bus.y         = y;
   assign bus.out_valid = v2;
   assign bus.evt_cnt   = evt_cnt_q;
   assign bus.trig      = trig_q;

`ifdef NT_NODE_PARITY_EN
   logic y_par_q, perr_q;

   always_ff @(posedge I1470_clk or negedge I1477_rst) begin
      if (!I1477_rst) begin
         y_par_q <= 1'(WIDTH % 2);
         perr_q  <= 1'b0;
      end else begin
         if (bus.en) y_par_q <= ^(~o_d);
         if (bus.clr) perr_q <= 1'b0;
         else if (v2 && ((^y) != y_par_q)) perr_q <= 1'b1;
      end
   end

   assign bus.y_par = y_par_q;
   assign bus.perr  = perr_q;
`endif
endmodule

// File: tb/tb_nt_node_lane_array.sv
// Self-checking bench for nt_node_lane_array: vector table, scoreboard queue, corner sequences.
module tb_nt_node_lane_array;
   import nt_node_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 8;
   localparam int unsigned TH = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] y;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nt_node_lane_array_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   nt_node_lane_array #(
      .WIDTH    (W),
      .CNT_W    (CW),
      .THRESH   (TH),
      .EVT_MASK ('1)
   ) dut (
      .I1470_clk (clk),
      .I1477_rst (rst_n),
      .bus       (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0]  sb_q[$];
   logic          mv1, mv2;
   lane_t         m1y, my;
   logic [CW-1:0] mcnt;
   logic          mtrig;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mv1 = 1'b0; mv2 = 1'b0; m1y = '0; my = '0;
      mcnt = '0; mtrig = 1'b0;
      sb_q.delete();
   endtask

   // One clock: drive at negedge, check 1ns after the rising edge, return at negedge.
   task automatic step(input logic e, input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ic, input logic [W-1:0] ey, input logic cl);
      logic          ev;
      logic [W-1:0]  exp_y;
      logic          old_trig_hit;
      bus.en = e; bus.in_valid = iv; bus.a = ia; bus.b = ib; bus.c = ic; bus.clr = cl;
      ev = mv2 && e && (my != '0);
      old_trig_hit = (mcnt >= CW'(TH));
      @(posedge clk);
      #1;
      if (e) begin
         my  = m1y; mv2 = mv1;
         m1y = ey;  mv1 = iv;
         if (iv) sb_q.push_back(ey);
      end
      if (cl) begin
         mcnt = '0; mtrig = 1'b0;
      end else begin
         if (old_trig_hit) mtrig = 1'b1;
         if (ev && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
      end
      chk("out_valid", 32'(bus.out_valid), 32'(mv2));
      chk("evt_cnt", 32'(bus.evt_cnt), 32'(mcnt));
      chk("trig", 32'(bus.trig), 32'(mtrig));
      if (e && mv2) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_y = sb_q.pop_front();
            chk("y", 32'(bus.y), 32'(exp_y));
         end
      end else if (!e && mv2) begin
         chk("y_stall_hold", 32'(bus.y), 32'(my));
      end
`ifdef NT_NODE_PARITY_EN
      chk("perr", 32'(bus.perr), 32'd0);
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      for (int unsigned i = 0; i < 3; i++) begin
         bus.en = 1'($urandom); bus.in_valid = 1'($urandom); bus.clr = 1'b0;
         bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
         @(posedge clk);
         #1;
         chk("rst_y", 32'(bus.y), 32'hFF);
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_evt_cnt", 32'(bus.evt_cnt), 32'd0);
         chk("rst_trig", 32'(bus.trig), 32'd0);
         @(negedge clk);
      end
      rst_n = 1'b1;
   endtask

   vec_t vecs[16];

   initial begin
      // Lane 3 truth table, then multi-lane patterns; y = (a|b) & ~c per lane.
      vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{8'h08, 8'h00, 8'h00, 8'h08};
      vecs[2]  = '{8'h00, 8'h08, 8'h00, 8'h08};
      vecs[3]  = '{8'h08, 8'h08, 8'h00, 8'h08};
      vecs[4]  = '{8'h00, 8'h00, 8'h08, 8'h00};
      vecs[5]  = '{8'h08, 8'h00, 8'h08, 8'h00};
      vecs[6]  = '{8'h00, 8'h08, 8'h08, 8'h00};
      vecs[7]  = '{8'h08, 8'h08, 8'h08, 8'h00};
      vecs[8]  = '{8'hF0, 8'h0F, 8'h00, 8'hFF};
      vecs[9]  = '{8'hAA, 8'h00, 8'h0F, 8'hA0};
      vecs[10] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
      vecs[11] = '{8'h3C, 8'hC3, 8'h81, 8'h7E};
      vecs[12] = '{8'h01, 8'h10, 8'h10, 8'h01};
      vecs[13] = '{8'h00, 8'h55, 8'h04, 8'h51};
      vecs[14] = '{8'h80, 8'h00, 8'h7F, 8'h80};
      vecs[15] = '{8'h00, 8'h00, 8'hFF, 8'h00};

      bus.en = 1'b0; bus.in_valid = 1'b0; bus.clr = 1'b0;
      bus.a = '0; bus.b = '0; bus.c = '0;
      do_reset();

      // First transaction: two enabled cycles to out_valid.
      step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Table stream with a 3-cycle stall in the middle.
      for (int unsigned i = 0; i < 16; i++) begin
         if (i == 6) begin
            for (int unsigned s = 0; s < 3; s++)
               step(1'b0, 1'($urandom), W'($urandom), W'($urandom), W'($urandom), 8'h00, 1'b0);
         end
         step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].y, 1'b0);
      end
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      // Mid-stream reset discards in-flight data; latency counts enabled cycles only.
      step(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0);
      step(1'b1, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h0F, 1'b0);
      do_reset();
      step(1'b1, 1'b1, 8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Threshold: clear, then one event per cycle on lane 0.
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("clr_cnt", 32'(bus.evt_cnt), 32'd0);
      for (int unsigned i = 0; i < 22; i++)
         step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
      chk("trig_set", 32'(bus.trig), 32'd1);

      // Saturation, then clr coincident with an event.
      for (int unsigned i = 0; i < 300; i++)
         step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
      chk("sat_cnt", 32'(bus.evt_cnt), 32'd255);
      step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
      chk("clr_evt_cnt", 32'(bus.evt_cnt), 32'd0);
      chk("clr_evt_trig", 32'(bus.trig), 32'd0);

      // clr while stalled still clears.
      step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
      step(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("clr_stall_cnt", 32'(bus.evt_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
